// File: rtl/definitions_pkg.sv
// Shared types and constants for the 3x3 window generator and its filter consumers.
package definitions_pkg;

  localparam int unsigned DEF_PIXEL_W = 8;
  localparam int unsigned WIN_W       = 9 * DEF_PIXEL_W;
  localparam int unsigned CENTRE_IDX  = 4;

  typedef logic [WIN_W-1:0] window_t;

  typedef enum logic {
    FILL,
    ACTIVE
  } state_t;

endpackage

// File: rtl/window_generator_if.sv
// Pixel-stream input and packed-window output of the window generator.
interface window_generator_if #(
    parameter int unsigned PIXEL_W = 8
);

    logic [PIXEL_W-1:0]   pixel_in;
    logic                 pixel_in_valid;
    logic                 pixel_in_sof;
    logic [9*PIXEL_W-1:0] window_out;
    logic                 window_out_valid;
    logic                 frame_done;

    modport master (
        output pixel_in, pixel_in_valid, pixel_in_sof,
        input  window_out, window_out_valid, frame_done
    );

    modport slave (
        input  pixel_in, pixel_in_valid, pixel_in_sof,
        output window_out, window_out_valid, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage; on en the old word at addr is read while the new one is written.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Turns a raster pixel stream into 3x3 neighbourhoods using two line buffers.
module window_generator
    import definitions_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned PIXEL_W    = DEF_PIXEL_W
) (
    input logic               clk,
    input logic               rstN,
    window_generator_if.slave bus
);

    localparam int unsigned COL_W    = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT);
    localparam int unsigned WINDOW_W = 9 * PIXEL_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_t              state;
    logic [COL_W-1:0]    col_cnt, cur_col, next_col;
    logic [ROW_W-1:0]    row_cnt, cur_row, next_row;
    logic                accept, start, last_in_row, last_in_frame, emit;
    logic [PIXEL_W-1:0]  lb0_out, lb1_out;
    logic [PIXEL_W-1:0]  win [3][3];
    logic [PIXEL_W-1:0]  win_next [3][3];
    logic [WINDOW_W-1:0] win_packed;

    assign accept = bus.pixel_in_valid;
    assign start  = accept & bus.pixel_in_sof;

    // SOF forces the accepted pixel to (0,0) whatever the counters say.
    assign cur_col = start ? '0 : col_cnt;
    assign cur_row = start ? '0 : row_cnt;

    always_comb begin
        last_in_row   = (cur_col == COL_LAST);
        last_in_frame = last_in_row && (cur_row == ROW_LAST);
        emit          = accept && (state == ACTIVE) && (cur_col >= COL_W'(2));

        next_col = cur_col + COL_W'(1);
        next_row = cur_row;
        if (last_in_row) begin
            next_col = '0;
            next_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        end

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_next[r][c] = win[r][c+1];
            end
        end
        win_next[0][2] = lb1_out;
        win_next[1][2] = lb0_out;
        win_next[2][2] = bus.pixel_in;

        win_packed = '0;
        for (int i = 0; i < 9; i++) begin
            win_packed[i*PIXEL_W +: PIXEL_W] = win_next[i/3][i%3];
        end
    end

    line_buffer #(
        .DEPTH(IMG_WIDTH),
        .WIDTH(PIXEL_W)
    ) u_lb0 (
        .clk    (clk),
        .en     (accept),
        .addr   (cur_col),
        .wr_data(bus.pixel_in),
        .rd_data(lb0_out)
    );

    line_buffer #(
        .DEPTH(IMG_WIDTH),
        .WIDTH(PIXEL_W)
    ) u_lb1 (
        .clk    (clk),
        .en     (accept),
        .addr   (cur_col),
        .wr_data(lb0_out),
        .rd_data(lb1_out)
    );

    // Window contents need no reset: rows 0-1 are refilled before any output.
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state                <= FILL;
            col_cnt              <= '0;
            row_cnt              <= '0;
            bus.window_out       <= '0;
            bus.window_out_valid <= 1'b0;
            bus.frame_done       <= 1'b0;
        end else begin
            bus.window_out_valid <= emit;
            bus.frame_done       <= emit && last_in_frame;
            if (emit) begin
                bus.window_out <= win_packed;
            end
            if (accept) begin
                col_cnt <= next_col;
                row_cnt <= next_row;
                unique case (state)
                    FILL:   if (cur_row == ROW_W'(1) && last_in_row) state <= ACTIVE;
                    ACTIVE: if (start || last_in_frame) state <= FILL;
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
